// File: rtl/writeback_stage.sv
// RV32I writeback stage: selects the writeback source, aligns and extends load data,
// and drives a registered single-cycle register-file write pulse plus a retire counter.
module writeback_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int REG_SIZE   = $clog2(REG_COUNT),
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_reg_write,
    input  logic [REG_SIZE-1:0]   in_rd,
    input  logic [1:0]            in_wb_sel,
    input  logic [DATA_WIDTH-1:0] in_alu_result,
    input  logic [DATA_WIDTH-1:0] in_pc_plus4,
    input  logic [2:0]            in_funct3,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rf_wen,
    output logic [REG_SIZE-1:0]   rf_rd,
    output logic [DATA_WIDTH-1:0] rf_data,
    output logic                  fwd_valid,
    output logic [REG_SIZE-1:0]   fwd_rd,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  load_err,
    output logic [CNT_WIDTH-1:0]  retire_cnt
);

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } state_e;

    state_e                state_q, state_d;
    logic                  rf_wen_q, rf_wen_d;
    logic [REG_SIZE-1:0]   rf_rd_q, rf_rd_d;
    logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
    logic                  load_err_q, load_err_d;
    logic [CNT_WIDTH-1:0]  retire_cnt_q, retire_cnt_d;
    logic                  ld_wen_q, ld_wen_d;
    logic [REG_SIZE-1:0]   ld_rd_q, ld_rd_d;
    logic [2:0]            ld_funct3_q, ld_funct3_d;
    logic [1:0]            ld_addr_q, ld_addr_d;

    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_value;
    logic                  ld_bad;

    // Field extraction for the captured load; ld_bad covers misalignment and unknown funct3.
    always_comb begin
        ld_byte  = mem_rdata[{ld_addr_q, 3'b000} +: 8];
        ld_half  = ld_addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_value = mem_rdata;
        ld_bad   = 1'b0;
        case (ld_funct3_q)
            3'b000:  ld_value = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_value = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b001: begin
                ld_value = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
                ld_bad   = ld_addr_q[0];
            end
            3'b101: begin
                ld_value = {{(DATA_WIDTH-16){1'b0}}, ld_half};
                ld_bad   = ld_addr_q[0];
            end
            3'b010: begin
                ld_value = mem_rdata;
                ld_bad   = (ld_addr_q != 2'b00);
            end
            default: ld_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rf_wen_d     = 1'b0;
        rf_rd_d      = rf_rd_q;
        rf_data_d    = rf_data_q;
        load_err_d   = 1'b0;
        retire_cnt_d = retire_cnt_q;
        ld_wen_d     = ld_wen_q;
        ld_rd_d      = ld_rd_q;
        ld_funct3_d  = ld_funct3_q;
        ld_addr_d    = ld_addr_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_wb_sel == 2'b01) begin
                        ld_wen_d    = in_reg_write && (in_rd != '0);
                        ld_rd_d     = in_rd;
                        ld_funct3_d = in_funct3;
                        ld_addr_d   = in_alu_result[1:0];
                        state_d     = WAIT_LOAD;
                    end else begin
                        rf_wen_d     = in_reg_write && (in_rd != '0);
                        retire_cnt_d = retire_cnt_q + 1'b1;
                        if (rf_wen_d) begin
                            rf_rd_d   = in_rd;
                            rf_data_d = (in_wb_sel == 2'b10) ? in_pc_plus4 : in_alu_result;
                        end
                    end
                end
            end
            WAIT_LOAD: begin
                if (mem_rvalid) begin
                    retire_cnt_d = retire_cnt_q + 1'b1;
                    state_d      = IDLE;
                    if (ld_bad) begin
                        load_err_d = 1'b1;
                    end else if (ld_wen_q) begin
                        rf_wen_d  = 1'b1;
                        rf_rd_d   = ld_rd_q;
                        rf_data_d = ld_value;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rf_wen_q     <= 1'b0;
            rf_rd_q      <= '0;
            rf_data_q    <= '0;
            load_err_q   <= 1'b0;
            retire_cnt_q <= '0;
            ld_wen_q     <= 1'b0;
            ld_rd_q      <= '0;
            ld_funct3_q  <= '0;
            ld_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            rf_wen_q     <= rf_wen_d;
            rf_rd_q      <= rf_rd_d;
            rf_data_q    <= rf_data_d;
            load_err_q   <= load_err_d;
            retire_cnt_q <= retire_cnt_d;
            ld_wen_q     <= ld_wen_d;
            ld_rd_q      <= ld_rd_d;
            ld_funct3_q  <= ld_funct3_d;
            ld_addr_q    <= ld_addr_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign rf_wen     = rf_wen_q;
    assign rf_rd      = rf_rd_q;
    assign rf_data    = rf_data_q;
    assign fwd_valid  = rf_wen_q;
    assign fwd_rd     = rf_rd_q;
    assign fwd_data   = rf_data_q;
    assign load_err   = load_err_q;
    assign retire_cnt = retire_cnt_q;

endmodule
